// File: rtl/y86_stat_pkg.sv
// y86_stat_pkg
// Shared Y86 status definitions: the 2-bit architectural status codes used by
// both the status generator and stat_monitor, and the stat_monitor state enum.
// No ports (package).
package y86_stat_pkg;

   // Architectural status codes of a completing instruction
   localparam logic [1:0] STAT_AOK = 2'b00;
   localparam logic [1:0] STAT_HLT = 2'b01;
   localparam logic [1:0] STAT_ADR = 2'b10;
   localparam logic [1:0] STAT_INS = 2'b11;

   // Monitor states: normal retirement, report pending to host, frozen
   typedef enum logic [1:0] {
      RUN    = 2'b00,
      REPORT = 2'b01,
      HALTED = 2'b10
   } mon_state_t;

endpackage

// File: rtl/stat_monitor_if.sv
// stat_monitor_if
// Groups the status stream from the core, the host handshake and the monitor
// outputs into one bundle.
//   Core/host -> monitor : stat_valid_i, stat_i, pc_i, report_ready_i, resume_i
//   Monitor -> core/host : stall_o, halted_o, cpu_stat_o, report_valid_o,
//                          report_stat_o, report_pc_o, instr_count_o
// Modports: master (core + host harness side), slave (stat_monitor side).
interface stat_monitor_if #(
   parameter int PC_WIDTH  = 64,
   parameter int CNT_WIDTH = 32
);

   logic                 stat_valid_i;
   logic [1:0]           stat_i;
   logic [PC_WIDTH-1:0]  pc_i;
   logic                 report_ready_i;
   logic                 resume_i;

   logic                 stall_o;
   logic                 halted_o;
   logic [1:0]           cpu_stat_o;
   logic                 report_valid_o;
   logic [1:0]           report_stat_o;
   logic [PC_WIDTH-1:0]  report_pc_o;
   logic [CNT_WIDTH-1:0] instr_count_o;

   modport master (
      output stat_valid_i, stat_i, pc_i, report_ready_i, resume_i,
      input  stall_o, halted_o, cpu_stat_o, report_valid_o,
             report_stat_o, report_pc_o, instr_count_o
   );

   modport slave (
      input  stat_valid_i, stat_i, pc_i, report_ready_i, resume_i,
      output stall_o, halted_o, cpu_stat_o, report_valid_o,
             report_stat_o, report_pc_o, instr_count_o
   );

endinterface

// File: rtl/stat_monitor_retire_counter.sv
// retire_counter
// Free-running unsigned counter of retired AOK instructions; wraps silently
// from all-ones to zero.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   inc_i   : add one at the next edge
//   count_o : current count (CNT_WIDTH bits)
module retire_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Count register; natural modulo-2^CNT_WIDTH wrap, no overflow flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (inc_i) begin
         count_o <= count_o + ONE;
      end
   end

endmodule

// File: rtl/stat_monitor.sv
// stat_monitor
// Watches the status of each completing Y86 instruction. Counts retired AOK
// instructions, captures the first non-AOK status with its PC, freezes the
// pipeline and hands the event to the debug host over a valid/ready
// handshake. The host releases the freeze with resume.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset; drops any pending report
//   bus   : stat_monitor_if.slave (status in, host handshake, all outputs)
// Configuration macro:
//   STAT_MONITOR_COUNT_EN - when defined, the retired-instruction counter is
//   built; otherwise instr_count_o is tied to zero.
// All outputs come straight from flops.
module stat_monitor
   import y86_stat_pkg::*;
#(
   parameter int PC_WIDTH  = 64,
   parameter int CNT_WIDTH = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   stat_monitor_if.slave bus
);

   mon_state_t          state_q;
   mon_state_t          state_d;
   logic                capture;
   logic                clear_stat;

   logic                stall_q;
   logic                halted_q;
   logic                report_valid_q;
   logic [1:0]          cpu_stat_q;
   logic [1:0]          report_stat_q;
   logic [PC_WIDTH-1:0] report_pc_q;

   // Next-state decode. Only RUN looks at the status stream, so beats that
   // arrive while reporting or halted (including during the resume cycle)
   // are dropped without side effects.
   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      clear_stat = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.stat_valid_i && (bus.stat_i != STAT_AOK)) begin
               capture = 1'b1;
               state_d = REPORT;
            end
         end
         REPORT: begin
            if (bus.report_ready_i) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            if (bus.resume_i) begin
               clear_stat = 1'b1;
               state_d    = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and output registers. Flags are decoded from the next state so
   // they change on the same edge as the state itself. The captured fields
   // only load on the RUN->REPORT transition, which keeps them stable for the
   // whole time valid is high; report_pc survives resume for post-mortem use.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= RUN;
         stall_q        <= 1'b0;
         halted_q       <= 1'b0;
         report_valid_q <= 1'b0;
         cpu_stat_q     <= STAT_AOK;
         report_stat_q  <= STAT_AOK;
         report_pc_q    <= '0;
      end else begin
         state_q        <= state_d;
         stall_q        <= (state_d != RUN);
         halted_q       <= (state_d == HALTED);
         report_valid_q <= (state_d == REPORT);
         if (capture) begin
            cpu_stat_q    <= bus.stat_i;
            report_stat_q <= bus.stat_i;
            report_pc_q   <= bus.pc_i;
         end else if (clear_stat) begin
            cpu_stat_q    <= STAT_AOK;
            report_stat_q <= STAT_AOK;
         end
      end
   end

   assign bus.stall_o        = stall_q;
   assign bus.halted_o       = halted_q;
   assign bus.report_valid_o = report_valid_q;
   assign bus.cpu_stat_o     = cpu_stat_q;
   assign bus.report_stat_o  = report_stat_q;
   assign bus.report_pc_o    = report_pc_q;

`ifdef STAT_MONITOR_COUNT_EN
   logic                 count_inc;
   logic [CNT_WIDTH-1:0] count;

   // Only AOK beats seen in RUN retire; the faulting instruction is excluded
   assign count_inc = (state_q == RUN) && bus.stat_valid_i && (bus.stat_i == STAT_AOK);

   retire_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_retire_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (count_inc),
      .count_o (count)
   );

   assign bus.instr_count_o = count;
`else
   assign bus.instr_count_o = '0;
`endif

endmodule

// File: tb/tb_stat_monitor.sv
// tb_stat_monitor
// Directed bench for stat_monitor: retirement counting, report capture and
// handshake, halted/resume behaviour, counter wrap (on a narrow-counter
// instance) and asynchronous reset in the middle of a report. Count
// expectations follow whether STAT_MONITOR_COUNT_EN is defined.
module tb_stat_monitor;
   import y86_stat_pkg::*;

`ifdef STAT_MONITOR_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   passCount;
   int   totalChecks;

   stat_monitor_if #(.PC_WIDTH(64), .CNT_WIDTH(32)) bus ();
   stat_monitor_if #(.PC_WIDTH(64), .CNT_WIDTH(3))  smallBus ();

   stat_monitor #(.PC_WIDTH(64), .CNT_WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // Narrow counter so the wrap from all-ones can be reached in a few beats
   stat_monitor #(.PC_WIDTH(64), .CNT_WIDTH(3)) dutSmall (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (smallBus.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected count in the current build
   function automatic logic [63:0] expCnt(input int n);
      return COUNT_EN ? 64'(n) : 64'd0;
   endfunction

   // Advance one active edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat of status from the core
   task automatic applyStimulus(input logic valid, input logic [1:0] st, input logic [63:0] pc);
      bus.stat_valid_i = valid;
      bus.stat_i       = st;
      bus.pc_i         = pc;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalChecks++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   initial begin
      passCount   = 0;
      totalChecks = 0;
      rst = 1'b1;
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      bus.report_ready_i      = 1'b0;
      bus.resume_i            = 1'b0;
      smallBus.stat_valid_i   = 1'b0;
      smallBus.stat_i         = STAT_AOK;
      smallBus.pc_i           = 64'h0;
      smallBus.report_ready_i = 1'b0;
      smallBus.resume_i       = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      $display("[TB] reset values");
      checkOutput("rst_stall",  64'(bus.stall_o), 64'd0);
      checkOutput("rst_halted", 64'(bus.halted_o), 64'd0);
      checkOutput("rst_valid",  64'(bus.report_valid_o), 64'd0);
      checkOutput("rst_cpu",    64'(bus.cpu_stat_o), 64'(STAT_AOK));
      checkOutput("rst_pc",     bus.report_pc_o, 64'd0);
      checkOutput("rst_count",  64'(bus.instr_count_o), 64'd0);

      $display("[TB] five AOK beats then HLT at 0x40");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, STAT_AOK, 64'(i * 4));
         step();
      end
      checkOutput("aok5_count", 64'(bus.instr_count_o), expCnt(5));
      checkOutput("aok5_valid", 64'(bus.report_valid_o), 64'd0);
      applyStimulus(1'b1, STAT_HLT, 64'h40);
      step();
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      checkOutput("hlt_valid",  64'(bus.report_valid_o), 64'd1);
      checkOutput("hlt_stall",  64'(bus.stall_o), 64'd1);
      checkOutput("hlt_stat",   64'(bus.report_stat_o), 64'(STAT_HLT));
      checkOutput("hlt_cpu",    64'(bus.cpu_stat_o), 64'(STAT_HLT));
      checkOutput("hlt_pc",     bus.report_pc_o, 64'h40);
      checkOutput("hlt_count",  64'(bus.instr_count_o), expCnt(5));
      bus.report_ready_i = 1'b1;
      step();
      bus.report_ready_i = 1'b0;
      checkOutput("hlt_halted", 64'(bus.halted_o), 64'd1);
      checkOutput("hlt_valid0", 64'(bus.report_valid_o), 64'd0);
      bus.resume_i = 1'b1;
      step();
      bus.resume_i = 1'b0;
      checkOutput("res1_stall", 64'(bus.stall_o), 64'd0);
      checkOutput("res1_cpu",   64'(bus.cpu_stat_o), 64'(STAT_AOK));
      checkOutput("res1_pc",    bus.report_pc_o, 64'h40);

      $display("[TB] INS at 0x1C with ready held low");
      applyStimulus(1'b1, STAT_INS, 64'h1C);
      step();
      // Beats and resume during REPORT must be ignored
      applyStimulus(1'b1, STAT_AOK, 64'h99);
      bus.resume_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ins_valid%0d", i), 64'(bus.report_valid_o), 64'd1);
         checkOutput($sformatf("ins_stat%0d", i),  64'(bus.report_stat_o), 64'(STAT_INS));
         checkOutput($sformatf("ins_pc%0d", i),    bus.report_pc_o, 64'h1C);
         step();
      end
      bus.resume_i = 1'b0;
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      checkOutput("ins_count",  64'(bus.instr_count_o), expCnt(5));
      checkOutput("ins_valid4", 64'(bus.report_valid_o), 64'd1);
      bus.report_ready_i = 1'b1;
      step();
      bus.report_ready_i = 1'b0;
      checkOutput("ins_halted", 64'(bus.halted_o), 64'd1);
      checkOutput("ins_valid0", 64'(bus.report_valid_o), 64'd0);
      checkOutput("ins_stall",  64'(bus.stall_o), 64'd1);

      $display("[TB] ADR and AOK while halted, then resume");
      applyStimulus(1'b1, STAT_ADR, 64'h55);
      step();
      applyStimulus(1'b1, STAT_AOK, 64'h56);
      step();
      checkOutput("hal_cpu",    64'(bus.cpu_stat_o), 64'(STAT_INS));
      checkOutput("hal_pc",     bus.report_pc_o, 64'h1C);
      checkOutput("hal_valid",  64'(bus.report_valid_o), 64'd0);
      checkOutput("hal_count",  64'(bus.instr_count_o), expCnt(5));
      applyStimulus(1'b1, STAT_ADR, 64'h66);
      bus.resume_i = 1'b1;
      step();
      bus.resume_i = 1'b0;
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      checkOutput("res2_stall",  64'(bus.stall_o), 64'd0);
      checkOutput("res2_halted", 64'(bus.halted_o), 64'd0);
      checkOutput("res2_cpu",    64'(bus.cpu_stat_o), 64'(STAT_AOK));
      checkOutput("res2_rstat",  64'(bus.report_stat_o), 64'(STAT_AOK));
      checkOutput("res2_valid",  64'(bus.report_valid_o), 64'd0);
      checkOutput("res2_pc",     bus.report_pc_o, 64'h1C);
      applyStimulus(1'b1, STAT_AOK, 64'h70);
      step();
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      checkOutput("res2_count", 64'(bus.instr_count_o), expCnt(6));

      $display("[TB] ready outside REPORT");
      bus.report_ready_i = 1'b1;
      step();
      step();
      bus.report_ready_i = 1'b0;
      checkOutput("rdy_valid", 64'(bus.report_valid_o), 64'd0);
      checkOutput("rdy_stall", 64'(bus.stall_o), 64'd0);
      checkOutput("rdy_count", 64'(bus.instr_count_o), expCnt(6));

      $display("[TB] async reset mid-REPORT");
      applyStimulus(1'b1, STAT_ADR, 64'h80);
      step();
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      checkOutput("ar_valid_pre", 64'(bus.report_valid_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_valid", 64'(bus.report_valid_o), 64'd0);
      checkOutput("ar_stall", 64'(bus.stall_o), 64'd0);
      checkOutput("ar_cpu",   64'(bus.cpu_stat_o), 64'(STAT_AOK));
      checkOutput("ar_rstat", 64'(bus.report_stat_o), 64'(STAT_AOK));
      checkOutput("ar_pc",    bus.report_pc_o, 64'd0);
      checkOutput("ar_count", 64'(bus.instr_count_o), 64'd0);
      step();
      rst = 1'b0;
      step();
      checkOutput("ar_after_valid", 64'(bus.report_valid_o), 64'd0);

      $display("[TB] ten AOK beats then HLT at 0x20");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, STAT_AOK, 64'(i));
         step();
      end
      checkOutput("aok10_count", 64'(bus.instr_count_o), expCnt(10));
      applyStimulus(1'b1, STAT_HLT, 64'h20);
      step();
      applyStimulus(1'b0, STAT_AOK, 64'h0);
      checkOutput("h20_valid", 64'(bus.report_valid_o), 64'd1);
      checkOutput("h20_pc",    bus.report_pc_o, 64'h20);
      checkOutput("h20_count", 64'(bus.instr_count_o), expCnt(10));

      $display("[TB] counter wrap on 3-bit instance");
      smallBus.stat_valid_i = 1'b1;
      smallBus.stat_i       = STAT_AOK;
      for (int i = 0; i < 7; i++) begin
         step();
      end
      checkOutput("wrap_full", 64'(smallBus.instr_count_o), expCnt(7));
      step();
      checkOutput("wrap_zero", 64'(smallBus.instr_count_o), 64'd0);
      step();
      smallBus.stat_valid_i = 1'b0;
      checkOutput("wrap_one", 64'(smallBus.instr_count_o), expCnt(1));
      checkOutput("wrap_valid", 64'(smallBus.report_valid_o), 64'd0);

      $display("[TB] %0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/stat_monitor.md
# stat_monitor

Sequential consumer of the Y86 status code. Each cycle it receives the 2-bit status of the instruction completing that cycle and counts retired AOK instructions. It captures the first non-AOK status together with its PC, freezes the pipeline, and reports the event to a debug host over a valid/ready handshake. It sits downstream of the status generator, between the CPU core and the host/testbench harness.

## Interface
Parameters:
- PC_WIDTH, 64, width of the captured PC
- CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset; asynchronous, active-high
- stat_valid_i  in  1  one instruction completes this cycle
- stat_i  in  2  its status: 00 AOK, 01 HLT, 10 ADR, 11 INS
- pc_i  in  PC_WIDTH  PC of the completing instruction
- report_ready_i  in  1  host accepts the report
- resume_i  in  1  host request to leave HALTED
- stall_o  out  1  freeze fetch/PC update
- halted_o  out  1  block is in HALTED
- cpu_stat_o  out  2  latched architectural status
- report_valid_o  out  1  report pending
- report_stat_o  out  2  captured status code
- report_pc_o  out  PC_WIDTH  captured PC
- instr_count_o  out  CNT_WIDTH  retired AOK instruction count

## Operation
- FSM states: RUN, REPORT, HALTED.
- Reset values: RUN; all outputs 0, so cpu_stat_o = AOK, count = 0, report_pc_o = 0.
- **RUN**
  - stat_valid_i with stat_i = AOK: count += 1.
  - stat_valid_i with stat_i != AOK:
    - latch stat_i into report_stat_o and cpu_stat_o; latch pc_i into report_pc_o;
    - go to REPORT;
    - the faulting or halting instruction is not counted.
  - stat_valid_i = 0: no change.
- **REPORT**
  - report_valid_o = 1, stall_o = 1.
  - report_stat_o and report_pc_o stay stable while valid.
  - report_ready_i = 1 completes the transfer; go to HALTED.
  - Valid never drops without a ready.
  - stat_valid_i, stat_i, pc_i and resume_i are ignored.
- **HALTED**
  - stall_o = 1, halted_o = 1; report_valid_o = 0.
  - resume_i = 1 goes to RUN; cpu_stat_o and report_stat_o clear to AOK.
  - report_pc_o keeps its value; count keeps its value.
  - stat_valid_i is ignored.
- Counter arithmetic: unsigned, CNT_WIDTH bits, wraps from all-ones to 0 with no flag.
- Reset asserted in any state, including mid-REPORT with valid high: immediate return to reset values; the pending report is dropped.

## Timing
- All outputs are registered.
- Status arrives with stat_valid_i in cycle N:
  - state, stall_o, report_valid_o and the latched fields update at edge N+1;
  - earliest HALTED is N+2, if ready is already high at N+1.
- Count increment is visible at the edge after the AOK beat.
- Back-to-back AOK beats count one per cycle.
- resume_i in cycle M: RUN, stall_o = 0 and halted_o = 0 at edge M+1. A stat_valid_i in cycle M is ignored.
- report_ready_i asserted outside REPORT has no effect.

## Configuration
- STAT_MONITOR_COUNT_EN
  - Defined: the retired-instruction counter is implemented as described.
  - Undefined: no counter flops; instr_count_o is tied to 0. FSM and reporting are unchanged.

## Structure
- Shared package y86_stat_pkg:
  - STAT_AOK/HLT/ADR/INS 2-bit constants, shared with the status generator;
  - the monitor state enum (RUN, REPORT, HALTED).
- One sub-module: retire_counter.
  - Ports: clk_i, rst_i, inc_i, count_o.
  - Parameterised by CNT_WIDTH.
  - Instantiated only under STAT_MONITOR_COUNT_EN.

## Test plan
- Reset, then 5 AOK beats, then HLT at pc_i = 0x40:
  - instr_count_o = 5; report_stat_o = 01; report_pc_o = 0x40;
  - report_valid_o high one cycle after the HLT beat; stall_o high.
- INS at pc_i = 0x1C with report_ready_i held low for 4 cycles:
  - report_valid_o stays high with stable fields;
  - ready high: HALTED next edge, halted_o = 1.
- In HALTED: drive stat_valid_i with ADR, then resume_i:
  - ADR ignored; after resume, cpu_stat_o = 00, stall_o = 0;
  - next AOK beat increments the count.
- Force count to 0xFFFF_FFFF, then 1 AOK beat: instr_count_o = 0.
- Assert rst_i asynchronously mid-REPORT with valid high: outputs return to reset values before the next clock edge.
- Build without STAT_MONITOR_COUNT_EN, run 10 AOK beats: instr_count_o stays 0 and reporting is unaffected.
